// File: rtl/apb_pwm_pkg.sv
// Shared definitions for the APB motor PWM block.
// Register word offsets (PADDR[4:2]) and CTRL / STATUS bit positions.
package apb_pwm_pkg;

    // Word offsets decoded from PADDR[4:2]
    localparam logic [2:0] OFS_CTRL   = 3'd0;
    localparam logic [2:0] OFS_PERIOD = 3'd1;
    localparam logic [2:0] OFS_DUTY0  = 3'd2;
    localparam logic [2:0] OFS_DUTY1  = 3'd3;
    localparam logic [2:0] OFS_STATUS = 3'd4;
    localparam logic [2:0] OFS_COUNT  = 3'd5;

    // CTRL bit indices
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_DIR_LO = 2;
    localparam int unsigned CTRL_DIR_HI = 3;

    // STATUS bit indices
    localparam int unsigned STAT_IRQ_PEND = 0;
    localparam int unsigned STAT_UPD_PEND = 1;

endpackage

// File: rtl/pwm_channel.sv
// One edge-aligned PWM channel with a double-buffered duty register.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   wr_i           commit strobe for the programmed duty value
//   wr_data_i      new programmed duty value
//   load_i         copy programmed duty into the active duty
//   en_i           channel enable (CTRL.EN)
//   cnt_i          shared period counter
//   duty_o         programmed duty, for register readback
//   pwm_o          registered PWM output
module pwm_channel #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_data_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] duty_o,
    output logic             pwm_o
);

    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_d     = wr_i ? wr_data_i : duty_q;
        // A load in the same cycle as a write takes the old programmed value
        duty_act_d = load_i ? duty_q : duty_act_q;
        pwm_d      = en_i & (cnt_i < duty_act_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            duty_q     <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign duty_o = duty_q;
    assign pwm_o  = pwm_q;

endmodule

// File: rtl/apb_pwm_motor.sv
// APB3 slave generating two edge-aligned PWM channels plus direction lines
// for the wheel motor drivers, with a period-wrap interrupt.
// Ports:
//   PCLK, PRESET                 clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request (PADDR[4:2] decoded)
//   PRDATA/PREADY/PSLVERR         APB response, zero wait states
//   FABINT                        level interrupt (IRQ_PEND & IRQ_EN)
//   PWM[1:0]                      bit0 left motor, bit1 right motor
//   DIR[1:0]                      registered copy of CTRL[3:2]
module apb_pwm_motor
    import apb_pwm_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PERIOD_RST = 999
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        FABINT,
    output logic [1:0]  PWM,
    output logic [1:0]  DIR
);

    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_pend_q, irq_pend_d;
    logic             upd_pend_q, upd_pend_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             pslverr_q, pslverr_d;
    logic             fabint_q, fabint_d;
    logic [1:0]       dir_q, dir_d;

    logic [CNT_W-1:0] duty0, duty1;
    logic             pwm0, pwm1;

    logic [2:0]  ofs;
    logic        en, wrap, load;
    logic        acc_err, wr_ok;
    logic        wr_ctrl, wr_period, wr_duty0, wr_duty1, wr_status;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign ofs  = PADDR[4:2];
    assign en   = ctrl_q[CTRL_EN];
    assign wrap = en & (cnt_q == period_act_q);
    // Active copies track the programmed ones while disabled
    assign load = ~en | wrap;

    // Offsets 6/7 are unmapped; COUNT is read-only
    assign acc_err = (ofs > OFS_COUNT) | (PWRITE & (ofs == OFS_COUNT));
    assign wr_ok   = PSEL & PENABLE & PWRITE & ~acc_err;

    assign wr_ctrl   = wr_ok & (ofs == OFS_CTRL);
    assign wr_period = wr_ok & (ofs == OFS_PERIOD);
    assign wr_duty0  = wr_ok & (ofs == OFS_DUTY0);
    assign wr_duty1  = wr_ok & (ofs == OFS_DUTY1);
    assign wr_status = wr_ok & (ofs == OFS_STATUS);

    always_comb begin
        rd_val = '0;
        case (ofs)
            OFS_CTRL:   rd_val = 32'(ctrl_q);
            OFS_PERIOD: rd_val = 32'(period_q);
            OFS_DUTY0:  rd_val = 32'(duty0);
            OFS_DUTY1:  rd_val = 32'(duty1);
            OFS_STATUS: rd_val = 32'({upd_pend_q, irq_pend_q});
            OFS_COUNT:  rd_val = 32'(cnt_q);
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        ctrl_d       = wr_ctrl ? PWDATA[3:0] : ctrl_q;
        period_d     = wr_period ? PWDATA[CNT_W-1:0] : period_q;
        period_act_d = load ? period_q : period_act_q;

        if (!en || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Set on wrap wins over a simultaneous W1C
        if (wrap) begin
            irq_pend_d = 1'b1;
        end else if (wr_status && PWDATA[STAT_IRQ_PEND]) begin
            irq_pend_d = 1'b0;
        end else begin
            irq_pend_d = irq_pend_q;
        end

        // A write coinciding with a load keeps the flag: the load used the old value
        if (wr_period || wr_duty0 || wr_duty1) begin
            upd_pend_d = 1'b1;
        end else if (load) begin
            upd_pend_d = 1'b0;
        end else begin
            upd_pend_d = upd_pend_q;
        end

        // Response is captured in the setup phase, stable through the access phase
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        if (PSEL && !PENABLE) begin
            pslverr_d = acc_err;
            prdata_d  = (!PWRITE && !acc_err) ? rd_val : '0;
        end

        fabint_d = irq_pend_q & ctrl_q[CTRL_IRQ_EN];
        dir_d    = ctrl_q[CTRL_DIR_HI:CTRL_DIR_LO];
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q       <= '0;
            period_q     <= CNT_W'(PERIOD_RST);
            period_act_q <= CNT_W'(PERIOD_RST);
            cnt_q        <= '0;
            irq_pend_q   <= 1'b0;
            upd_pend_q   <= 1'b0;
            prdata_q     <= '0;
            pslverr_q    <= 1'b0;
            fabint_q     <= 1'b0;
            dir_q        <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            period_q     <= period_d;
            period_act_q <= period_act_d;
            cnt_q        <= cnt_d;
            irq_pend_q   <= irq_pend_d;
            upd_pend_q   <= upd_pend_d;
            prdata_q     <= prdata_d;
            pslverr_q    <= pslverr_d;
            fabint_q     <= fabint_d;
            dir_q        <= dir_d;
        end
    end

    pwm_channel #(
        .CNT_W (CNT_W)
    ) u_ch0 (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .wr_i      (wr_duty0),
        .wr_data_i (PWDATA[CNT_W-1:0]),
        .load_i    (load),
        .en_i      (en),
        .cnt_i     (cnt_q),
        .duty_o    (duty0),
        .pwm_o     (pwm0)
    );

    pwm_channel #(
        .CNT_W (CNT_W)
    ) u_ch1 (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .wr_i      (wr_duty1),
        .wr_data_i (PWDATA[CNT_W-1:0]),
        .load_i    (load),
        .en_i      (en),
        .cnt_i     (cnt_q),
        .duty_o    (duty1),
        .pwm_o     (pwm1)
    );

    // Upper address/data bits are intentionally ignored
    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

    assign PRDATA  = prdata_q;
    assign PREADY  = 1'b1;
    assign PSLVERR = pslverr_q;
    assign FABINT  = fabint_q;
    assign PWM     = {pwm1, pwm0};
    assign DIR     = dir_q;

endmodule

// File: tb/tb_apb_pwm_motor.sv
// Self-checking bench for apb_pwm_motor: register-access vector table,
// hand-written shadow/interrupt/reset sequences and randomized PWM runs
// checked against a closed-form model of the period/duty/interrupt rules.
module tb_apb_pwm_motor;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_PERIOD = 32'h04;
    localparam logic [31:0] A_DUTY0  = 32'h08;
    localparam logic [31:0] A_DUTY1  = 32'h0C;
    localparam logic [31:0] A_STATUS = 32'h10;
    localparam logic [31:0] A_COUNT  = 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr, fabint;
    logic [1:0]  pwm, dir;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_pwm_motor #(
        .CNT_W      (16),
        .PERIOD_RST (999)
    ) dut (
        .PCLK    (clk),
        .PRESET  (rst),
        .PSEL    (psel),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PRDATA  (prdata),
        .PREADY  (pready),
        .PSLVERR (pslverr),
        .FABINT  (fabint),
        .PWM     (pwm),
        .DIR     (dir)
    );

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All APB tasks start and end just after a negedge
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        data = prdata;
        err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic e;
        apb_write(addr, data, e);
    endtask

    // Program, enable with IRQ_EN, and compare every cycle with the closed form:
    // j cycles after EN commits, counter = j mod (P+1), PWM[n] = ((j-1) mod (P+1)) < Dn,
    // first wrap sets IRQ_PEND at j = P+1, FABINT follows one cycle later.
    task automatic run_enabled(input int p, input int d0, input int d1,
                               input logic [1:0] dr, input int n);
        logic [31:0] rd;
        logic        e;
        int          c;
        wr(A_CTRL, 32'h0);
        wr(A_PERIOD, 32'(p));
        wr(A_DUTY0, 32'(d0));
        wr(A_DUTY1, 32'(d1));
        wr(A_STATUS, 32'h1);
        wr(A_CTRL, {28'h0, dr, 2'b11});
        check("run j0 pwm", 32'(pwm), 32'h0);
        check("run j0 dir", 32'(dir), 32'h0);
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            c = (j - 1) % (p + 1);
            check($sformatf("run P%0d j%0d pwm0", p, j), 32'(pwm[0]), 32'(c < d0));
            check($sformatf("run P%0d j%0d pwm1", p, j), 32'(pwm[1]), 32'(c < d1));
            check($sformatf("run P%0d j%0d fabint", p, j), 32'(fabint), 32'(j >= p + 2));
            check($sformatf("run P%0d j%0d dir", p, j), 32'(dir), 32'(dr));
        end
        apb_read(A_COUNT, rd, e);
        check($sformatf("run P%0d count", p), rd, 32'(n % (p + 1)));
        check("run count err", 32'(e), 32'h0);
        wr(A_CTRL, 32'h0);
    endtask

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[19];

    initial begin
        logic [31:0] rd;
        logic        e;
        int          p, d0, d1, c, dact;

        vecs[0]  = '{1'b0, A_CTRL,   32'h0,     32'h0,   1'b0};
        vecs[1]  = '{1'b0, A_PERIOD, 32'h0,     32'd999, 1'b0};
        vecs[2]  = '{1'b0, A_DUTY0,  32'h0,     32'h0,   1'b0};
        vecs[3]  = '{1'b0, A_DUTY1,  32'h0,     32'h0,   1'b0};
        vecs[4]  = '{1'b0, A_STATUS, 32'h0,     32'h0,   1'b0};
        vecs[5]  = '{1'b0, A_COUNT,  32'h0,     32'h0,   1'b0};
        vecs[6]  = '{1'b0, 32'h18,   32'h0,     32'h0,   1'b1};
        vecs[7]  = '{1'b0, 32'h1C,   32'h0,     32'h0,   1'b1};
        vecs[8]  = '{1'b1, A_PERIOD, 32'd9,     32'h0,   1'b0};
        vecs[9]  = '{1'b0, A_PERIOD, 32'h0,     32'd9,   1'b0};
        vecs[10] = '{1'b1, A_COUNT,  32'h55,    32'h0,   1'b1};
        vecs[11] = '{1'b0, A_COUNT,  32'h0,     32'h0,   1'b0};
        vecs[12] = '{1'b1, A_DUTY1,  32'h10005, 32'h0,   1'b0};
        vecs[13] = '{1'b0, A_DUTY1,  32'h0,     32'h5,   1'b0};
        vecs[14] = '{1'b1, A_CTRL,   32'hFC,    32'h0,   1'b0};
        vecs[15] = '{1'b0, A_CTRL,   32'h0,     32'hC,   1'b0};
        vecs[16] = '{1'b1, A_CTRL,   32'h0,     32'h0,   1'b0};
        vecs[17] = '{1'b1, 32'h18,   32'h1,     32'h0,   1'b1};
        vecs[18] = '{1'b0, A_STATUS, 32'h0,     32'h0,   1'b0};

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(negedge clk);
        check("reset pwm", 32'(pwm), 32'h0);
        check("reset fabint", 32'(fabint), 32'h0);
        check("reset dir", 32'(dir), 32'h0);
        check("reset pready", 32'(pready), 32'h1);
        check("reset pslverr", 32'(pslverr), 32'h0);
        check("reset prdata", prdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].is_wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, e);
            end else begin
                apb_read(vecs[i].addr, rd, e);
                check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            end
            check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
        end

        // Basic PWM: 3-of-10 on channel 0, 100 % on channel 1
        run_enabled(9, 3, 10, 2'b00, 35);

        // Shadow update: DUTY0 = 7 committed at counter = 2
        wr(A_CTRL, 32'h0); wr(A_PERIOD, 32'd9); wr(A_DUTY0, 32'd3);
        wr(A_DUTY1, 32'd10); wr(A_STATUS, 32'h1); wr(A_CTRL, 32'h1);
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            c    = (j - 1) % 10;
            dact = ((j - 1) / 10 == 0) ? 3 : 7;
            check($sformatf("shadow j%0d pwm0", j), 32'(pwm[0]), 32'(c < dact));
            check($sformatf("shadow j%0d pwm1", j), 32'(pwm[1]), 32'h1);
            check($sformatf("shadow j%0d fabint", j), 32'(fabint), 32'h0);
            if (j == 5) check("shadow status mid", prdata, 32'h2);
            if (j == 13) check("shadow status next", prdata, 32'h1);
            case (j)
                1: begin psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
                         paddr = A_DUTY0; pwdata = 32'd7; end
                4: begin psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_STATUS; end
                12: begin psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_STATUS; end
                2, 5, 13: penable = 1'b1;
                3, 6, 14: begin psel = 1'b0; penable = 1'b0; end
                default: ;
            endcase
        end
        wr(A_CTRL, 32'h0);

        // Interrupt: PERIOD = 4, wraps at j = 5, 10, 15; clears commit at 8 and 15
        wr(A_PERIOD, 32'd4); wr(A_DUTY0, 32'd2); wr(A_DUTY1, 32'd0);
        wr(A_STATUS, 32'h1); wr(A_CTRL, 32'h3);
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            check($sformatf("irq j%0d fabint", j), 32'(fabint),
                  32'((j >= 6 && j <= 8) || j >= 11));
            check($sformatf("irq j%0d pwm0", j), 32'(pwm[0]), 32'(((j - 1) % 5) < 2));
            if (j == 16) begin
                check("irq clear-on-wrap status", prdata, 32'h1);
                check("irq status err", 32'(pslverr), 32'h0);
            end
            case (j)
                6, 13: begin psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
                             paddr = A_STATUS; pwdata = 32'h1; end
                15: begin psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_STATUS; end
                7, 14, 16: penable = 1'b1;
                8, 17: begin psel = 1'b0; penable = 1'b0; end
                default: ;
            endcase
        end
        wr(A_CTRL, 32'h0);

        // Boundaries: PERIOD = 0, and DUTY0 = 0 with DUTY1 > PERIOD
        run_enabled(0, 1, 0, 2'b01, 10);
        run_enabled(5, 0, 6, 2'b11, 20);

        for (int k = 0; k < 15; k++) begin
            p  = int'($urandom_range(0, 12));
            d0 = int'($urandom_range(0, 32'(p + 2)));
            d1 = int'($urandom_range(0, 32'(p + 2)));
            run_enabled(p, d0, d1, 2'($urandom_range(0, 3)), 2 * (p + 1) + 4);
        end

        // Reset mid-count, with a write in flight during reset
        wr(A_PERIOD, 32'd4); wr(A_DUTY0, 32'd5); wr(A_STATUS, 32'h1); wr(A_CTRL, 32'hB);
        repeat (8) @(negedge clk);
        check("prerst pwm0", 32'(pwm[0]), 32'h1);
        check("prerst fabint", 32'(fabint), 32'h1);
        check("prerst dir", 32'(dir), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst pwm", 32'(pwm), 32'h0);
        check("midrst fabint", 32'(fabint), 32'h0);
        check("midrst dir", 32'(dir), 32'h0);
        apb_write(A_CTRL, 32'hF, e);
        rst = 1'b0;
        apb_read(A_COUNT, rd, e);
        check("postrst count", rd, 32'h0);
        apb_read(A_PERIOD, rd, e);
        check("postrst period", rd, 32'd999);
        apb_read(A_CTRL, rd, e);
        check("postrst ctrl", rd, 32'h0);
        check("postrst pslverr", 32'(e), 32'h0);
        apb_read(A_STATUS, rd, e);
        check("postrst status", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_pwm_motor.md
Name: apb_pwm_motor

Overview:
- APB3 slave in the fabric, directly downstream of the controller MSS APB master port (MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA → PSEL/PENABLE/PWRITE/PADDR/PWDATA; PRDATA/PREADY/PSLVERR → MSSPRDATA/MSSPREADY/MSSPSLVERR).
- Generates two edge-aligned PWM channels plus direction lines for the Segway wheel motor drivers.
- Raises a period-wrap interrupt on FABINT so firmware can update duty cycles once per PWM period.

Parameters:
- CNT_W, 16, width of the period counter, PERIOD and DUTY registers (2..32).
- PERIOD_RST, 999, reset value of PERIOD. At a 10 MHz PCLK this gives 10 kHz PWM.

Ports:
- PCLK  in  1  fabric clock (FAB_CLK from the MSS).
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  32  byte address. Only [4:2] are decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  constant 1.
- PSLVERR  out  1  error response.
- FABINT  out  1  level interrupt to the MSS.
- PWM  out  2  PWM outputs; bit0 = left motor, bit1 = right motor.
- DIR  out  2  direction outputs.

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL rw: [0] EN, [1] IRQ_EN, [3:2] DIR.
  - 0x04 PERIOD rw.
  - 0x08 DUTY0 rw.
  - 0x0C DUTY1 rw.
  - 0x10 STATUS: [0] IRQ_PEND is W1C; [1] UPD_PEND is RO.
  - 0x14 COUNT ro.
  - 0x18 and 0x1C are unmapped.
  - Unused bits read 0. Values are zero-extended to 32 bits.
- Reset values:
  - CTRL = 0, PERIOD = PERIOD_RST, DUTY0 = DUTY1 = 0, all shadows equal their registers.
  - Counter = 0, IRQ_PEND = 0, UPD_PEND = 0.
  - PRDATA = 0, PSLVERR = 0, FABINT = 0, PWM = 0, DIR = 0.
- APB protocol:
  - No wait states; PREADY = 1 always.
  - Setup phase (PSEL & !PENABLE): PRDATA and PSLVERR are registered from the PADDR decode, so they are valid throughout the access phase.
  - PSLVERR = 1 for offsets 0x18/0x1C, and for writes to COUNT.
  - Writes commit on the clock edge of the access phase (PSEL & PENABLE & PWRITE).
  - A write that errors has no effect.
  - Reads have no side effects.
- Double buffering:
  - Writes to PERIOD/DUTYn land in the programmed registers and set UPD_PEND.
  - The active copies load from the programmed registers when either (a) EN = 0, in which case they load every cycle, or (b) EN = 1 and the counter is at the wrap point. Loading clears UPD_PEND.
  - If a write to PERIOD/DUTYn commits in the same cycle as a load, the load uses the old value and UPD_PEND stays 1.
- Counter:
  - EN = 0: counter is held at 0.
  - EN = 1: counter increments each cycle; when counter == active PERIOD it wraps to 0 on the next cycle.
  - PERIOD = 0 means the counter stays at 0 and wraps every cycle.
- PWM output:
  - PWM[n] is registered: PWM[n] <= EN & (counter < active DUTYn).
  - This adds 1 cycle of latency from the counter.
  - DUTYn = 0 gives a constant 0. DUTYn > PERIOD gives a constant 1, i.e. 100 %.
  - When EN falls, PWM goes to 0 on the next edge.
- DIR = CTRL[3:2], registered; it changes 1 cycle after the write commits.
- Interrupt:
  - IRQ_PEND is set on every wrap while EN = 1, regardless of IRQ_EN.
  - Writing 1 to STATUS[0] clears it. If the clear and a wrap occur in the same cycle, the set wins.
  - FABINT = IRQ_PEND & IRQ_EN, registered (1-cycle latency).
- Reset asserted mid-operation forces all reset values on the next edge, overriding any simultaneous APB write.
- States: no explicit FSM. The APB path has two phases (IDLE/SETUP → ACCESS) implied by PSEL/PENABLE.

Decomposition:
- Shared package apb_pwm_pkg:
  - Register offset constants: OFS_CTRL, OFS_PERIOD, OFS_DUTY0, OFS_DUTY1, OFS_STATUS, OFS_COUNT.
  - CTRL bit-index constants.
- One natural sub-module, pwm_channel:
  - Holds the programmed and active DUTY registers and the compare/registered output.
  - Takes the counter, the load strobe and EN.
  - Instantiated twice.
- The counter, APB decode and IRQ logic live in the top level.

Test Plan:
- Reset: assert PRESET for 3 cycles mid-count with EN = 1 → on the next edge PWM = 0, FABINT = 0 and COUNT reads 0. PERIOD reads 999, CTRL reads 0, PSLVERR = 0.
- Basic PWM: write PERIOD = 9, DUTY0 = 3, DUTY1 = 10, then CTRL = 0x1 → PWM[0] is high for 3 of every 10 cycles and PWM[1] is constantly 1. Counter runs 0..9.
- Shadow update: with EN = 1, write DUTY0 = 7 at counter = 2 → STATUS[1] = 1, and PWM[0] keeps 3-cycle high pulses until the wrap. From the next period it gives 7-cycle pulses and STATUS[1] = 0.
- Interrupt: CTRL = 0x3, PERIOD = 4 → FABINT rises 1 cycle after the first wrap. Write STATUS = 0x1 on a cycle not coinciding with a wrap → FABINT falls. Clear coinciding with a wrap → IRQ_PEND stays 1.
- APB errors: read 0x18 → PSLVERR = 1, PRDATA = 0. Write 0x14 = 0x55 → PSLVERR = 1 and COUNT is unaffected. Write CTRL = 0xC → DIR = 2'b11 one cycle later.
- Boundaries: PERIOD = 0 with DUTY0 = 1 → PWM[0] constantly 1 and IRQ_PEND sets every cycle. DUTY0 = 0 → PWM[0] constantly 0.
